// File: rtl/prio_arbiter_amisha.sv
// ---------------------------------------------------------------------------
// prio_arbiter_amisha
//   Four-requester arbiter sharing one resource between requesters r[4:1].
//   The winner is chosen in IDLE, either by fixed priority (highest index
//   wins) or round-robin (search descends from a rotating top pointer).
//   A grant is held while its requester keeps requesting. It is cut after
//   MAX_HOLD cycles, and every grant is followed by one GAP cycle before
//   arbitration resumes.
//
// Parameters
//   MAX_HOLD      : max consecutive grant cycles per requester (1..255)
// Ports
//   clk_amisha    : in   clock, all state changes on the rising edge
//   reset_amisha  : in   synchronous active-high reset
//   r_amisha      : in   [4:1] request lines
//   rr_amisha     : in   0 = fixed priority, 1 = round-robin (IDLE only)
//   g_amisha      : out  [4:1] registered one-hot grant
//   y_amisha      : out  [2:0] registered encoded grant (0 = none)
//   busy_amisha   : out  registered, high while a grant is active
//   expire_amisha : out  registered one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module prio_arbiter_amisha #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk_amisha,
   input  logic       reset_amisha,
   input  logic [4:1] r_amisha,
   input  logic       rr_amisha,
   output logic [4:1] g_amisha,
   output logic [2:0] y_amisha,
   output logic       busy_amisha,
   output logic       expire_amisha
);

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] top_q, top_d;
   logic [4:1] g_q, g_d;
   logic [2:0] y_q, y_d;
   logic       busy_q, busy_d;
   logic       expire_q, expire_d;
   logic [2:0] win_s;
   logic       held_req_s;

   // Highest requesting index wins; 0 when nobody requests.
   function automatic logic [2:0] pick_fixed(input logic [4:1] req);
      logic [2:0] w;
      if (req[4]) begin
         w = 3'd4;
      end else if (req[3]) begin
         w = 3'd3;
      end else if (req[2]) begin
         w = 3'd2;
      end else if (req[1]) begin
         w = 3'd1;
      end else begin
         w = 3'd0;
      end
      return w;
   endfunction

   // Search starts at top and descends, wrapping from 1 back to 4.
   function automatic logic [2:0] pick_rr(input logic [4:1] req, input logic [2:0] top);
      logic [2:0] w;
      logic [2:0] idx;
      w   = 3'd0;
      idx = top;
      for (int i = 0; i < 4; i++) begin
         if ((w == 3'd0) && req[idx]) begin
            w = idx;
         end else begin
            w = w;
         end
         idx = (idx == 3'd1) ? 3'd4 : (idx - 3'd1);
      end
      return w;
   endfunction

   // Encoded index to one-hot grant vector.
   function automatic logic [4:1] decode(input logic [2:0] idx);
      logic [4:1] oh;
      case (idx)
         3'd1:    oh = 4'b0001;
         3'd2:    oh = 4'b0010;
         3'd3:    oh = 4'b0100;
         3'd4:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   // Winner candidate and whether the current grantee still requests.
   always_comb begin
      win_s      = rr_amisha ? pick_rr(r_amisha, top_q) : pick_fixed(r_amisha);
      held_req_s = |(r_amisha & g_q);
   end

   // Next-state and next-output logic; outputs default to the idle value.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      top_d    = top_q;
      g_d      = 4'b0000;
      y_d      = 3'd0;
      busy_d   = 1'b0;
      expire_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_s != 3'd0) begin
               state_d = ST_GRANT;
               cnt_d   = 8'd1;
               g_d     = decode(win_s);
               y_d     = win_s;
               busy_d  = 1'b1;
               // Only round-robin grants rotate the pointer.
               if (rr_amisha) begin
                  top_d = (win_s == 3'd1) ? 3'd4 : (win_s - 3'd1);
               end else begin
                  top_d = top_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // A voluntary drop takes precedence over the hold limit.
            if (!held_req_s) begin
               state_d = ST_GAP;
               cnt_d   = 8'd0;
            end else if (cnt_q == MAX_HOLD_C) begin
               state_d  = ST_GAP;
               cnt_d    = 8'd0;
               expire_d = 1'b1;
            end else begin
               cnt_d  = cnt_q + 8'd1;
               g_d    = g_q;
               y_d    = y_q;
               busy_d = 1'b1;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_amisha) begin
      if (reset_amisha) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         top_q    <= 3'd4;
         g_q      <= 4'b0000;
         y_q      <= 3'd0;
         busy_q   <= 1'b0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         top_q    <= top_d;
         g_q      <= g_d;
         y_q      <= y_d;
         busy_q   <= busy_d;
         expire_q <= expire_d;
      end
   end

   assign g_amisha      = g_q;
   assign y_amisha      = y_q;
   assign busy_amisha   = busy_q;
   assign expire_amisha = expire_q;

endmodule

// File: tb/tb_prio_arbiter_amisha.sv
// ---------------------------------------------------------------------------
// tb_prio_arbiter_amisha
//   Directed bench for prio_arbiter_amisha. Two instances share all inputs:
//   u8 uses MAX_HOLD=8 and u2 uses MAX_HOLD=2. Each step checks the packed
//   observation {g, y, busy, expire} against a hand-computed value.
// ---------------------------------------------------------------------------
module tb_prio_arbiter_amisha;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:1] r;
   logic       rr;
   logic [4:1] g8, g2;
   logic [2:0] y8, y2;
   logic       b8, b2, e8, e2;
   logic [8:0] o8, o2;
   int         vectors = 0;
   int         fails   = 0;

   prio_arbiter_amisha #(.MAX_HOLD(8)) u8 (
      .clk_amisha(clk), .reset_amisha(reset), .r_amisha(r), .rr_amisha(rr),
      .g_amisha(g8), .y_amisha(y8), .busy_amisha(b8), .expire_amisha(e8)
   );

   prio_arbiter_amisha #(.MAX_HOLD(2)) u2 (
      .clk_amisha(clk), .reset_amisha(reset), .r_amisha(r), .rr_amisha(rr),
      .g_amisha(g2), .y_amisha(y2), .busy_amisha(b2), .expire_amisha(e2)
   );

   assign o8 = {g8, y8, b8, e8};
   assign o2 = {g2, y2, b2, e2};

   always #5 clk = ~clk;

   // Expected packed observation; busy follows from a non-zero grant.
   function automatic logic [8:0] ex(input logic [3:0] eg, input logic [2:0] ey, input logic ee);
      return {eg, ey, (eg != 4'b0000), ee};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed g/y/busy/expire=%b, expected %b", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      r     = 4'b0000;
      rr    = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      r     = 4'b0000;
      rr    = 1'b0;

      // 1: reset for two edges, then idle for five
      tick(); chk("rst8_a", o8, ex(4'b0000, 3'd0, 1'b0)); chk("rst2_a", o2, ex(4'b0000, 3'd0, 1'b0));
      tick(); chk("rst8_b", o8, ex(4'b0000, 3'd0, 1'b0)); chk("rst2_b", o2, ex(4'b0000, 3'd0, 1'b0));
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); chk("idle8", o8, ex(4'b0000, 3'd0, 1'b0)); chk("idle2", o2, ex(4'b0000, 3'd0, 1'b0));
      end

      // 2: fixed priority, 4 beats 2, drop after three grant cycles
      r = 4'b1010;
      tick(); chk("t2_g4_1", o8, ex(4'b1000, 3'd4, 1'b0));
      tick(); chk("t2_g4_2", o8, ex(4'b1000, 3'd4, 1'b0));
      tick(); chk("t2_g4_3", o8, ex(4'b1000, 3'd4, 1'b0));
      r = 4'b0010;
      tick(); chk("t2_gap", o8, ex(4'b0000, 3'd0, 1'b0));
      tick(); chk("t2_idle", o8, ex(4'b0000, 3'd0, 1'b0));
      tick(); chk("t2_g2", o8, ex(4'b0010, 3'd2, 1'b0));
      do_reset();

      // 3: requester 1 held constant, forced release after 8 cycles
      r = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         tick(); chk("t3_hold", o8, ex(4'b0001, 3'd1, 1'b0));
      end
      tick(); chk("t3_expire", o8, ex(4'b0000, 3'd0, 1'b1));
      tick(); chk("t3_idle", o8, ex(4'b0000, 3'd0, 1'b0));
      tick(); chk("t3_regrant", o8, ex(4'b0001, 3'd1, 1'b0));
      do_reset();

      // 4: round-robin, MAX_HOLD=2, all requesting
      rr = 1'b1;
      r  = 4'b1111;
      begin
         logic [2:0] order [5];
         order = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd4};
         for (int k = 0; k < 5; k++) begin
            tick(); chk("t4_g_a", o2, ex(4'b0001 << (order[k] - 3'd1), order[k], 1'b0));
            tick(); chk("t4_g_b", o2, ex(4'b0001 << (order[k] - 3'd1), order[k], 1'b0));
            tick(); chk("t4_exp", o2, ex(4'b0000, 3'd0, 1'b1));
            tick(); chk("t4_idle", o2, ex(4'b0000, 3'd0, 1'b0));
         end
      end
      do_reset();
      chk("t4_rst8", o8, ex(4'b0000, 3'd0, 1'b0));

      // 5: round-robin grant to 3 moves top to 2; reset must restore top to 4
      rr = 1'b1;
      r  = 4'b0100;
      tick(); chk("t5_g3", o8, ex(4'b0100, 3'd3, 1'b0));
      reset = 1'b1;
      tick(); chk("t5_rst8", o8, ex(4'b0000, 3'd0, 1'b0)); chk("t5_rst2", o2, ex(4'b0000, 3'd0, 1'b0));
      reset = 1'b0;
      r     = 4'b0101;
      tick(); chk("t5_top8", o8, ex(4'b0100, 3'd3, 1'b0)); chk("t5_top2", o2, ex(4'b0100, 3'd3, 1'b0));
      do_reset();

      // 6: higher request arriving during a grant is ignored
      r = 4'b0010;
      tick(); chk("t6_g2_a", o8, ex(4'b0010, 3'd2, 1'b0));
      r = 4'b1010;
      tick(); chk("t6_g2_b", o8, ex(4'b0010, 3'd2, 1'b0));
      tick(); chk("t6_g2_c", o8, ex(4'b0010, 3'd2, 1'b0));
      r = 4'b1000;
      tick(); chk("t6_gap", o8, ex(4'b0000, 3'd0, 1'b0));
      tick(); chk("t6_idle", o8, ex(4'b0000, 3'd0, 1'b0));
      tick(); chk("t6_g4", o8, ex(4'b1000, 3'd4, 1'b0));
      do_reset();

      // 7: drop on the same edge the hold limit is reached: no expire
      r = 4'b0001;
      tick(); chk("t7_g1_a", o2, ex(4'b0001, 3'd1, 1'b0));
      tick(); chk("t7_g1_b", o2, ex(4'b0001, 3'd1, 1'b0));
      r = 4'b0000;
      tick(); chk("t7_noexp", o2, ex(4'b0000, 3'd0, 1'b0));
      tick(); chk("t7_idle", o2, ex(4'b0000, 3'd0, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
